// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - opcodes, FSM states and flag-bank ordering shared by the ULA and its control unit
package ula_pkg;

  localparam logic [3:0] ULA_ADD   = 4'd0;
  localparam logic [3:0] ULA_SUB   = 4'd1;
  localparam logic [3:0] ULA_AND   = 4'd2;
  localparam logic [3:0] ULA_OR    = 4'd3;
  localparam logic [3:0] ULA_NOT   = 4'd4;
  localparam logic [3:0] ULA_SHL   = 4'd5;
  localparam logic [3:0] ULA_PASSA = 4'd6;
  localparam logic [3:0] ULA_PASSB = 4'd7;
  localparam logic [3:0] ULA_MUL   = 4'd8;
  localparam logic [3:0] ULA_DIV   = 4'd9;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_ITER = 2'd1,
    DIV_ITER = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Bit positions in the flag bank; the control unit indexes flags with these.
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_MAIOR = 4;
  localparam int FLAG_MENOR = 5;
  localparam int FLAG_IGUAL = 6;
  localparam int FLAG_DIVZ  = 7;
  localparam int NUM_FLAGS  = 8;

  // cmp is {maior, menor, igual}
  function automatic logic [NUM_FLAGS-1:0] pack_flags(input logic zero, input logic neg,
                                                      input logic carry, input logic ovf,
                                                      input logic [2:0] cmp, input logic div_zero);
    logic [NUM_FLAGS-1:0] f;
    f             = '0;
    f[FLAG_ZERO]  = zero;
    f[FLAG_NEG]   = neg;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    f[FLAG_MAIOR] = cmp[2];
    f[FLAG_MENOR] = cmp[1];
    f[FLAG_IGUAL] = cmp[0];
    f[FLAG_DIVZ]  = div_zero;
    return f;
  endfunction

endpackage

// File: rtl/ula_muldiv_iter.sv
// rtl/ula_muldiv_iter.sv - shared accumulator/shift/counter datapath for shift-add MUL and restoring DIV
module ula_muldiv_iter #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             load_div,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi_next,
  output logic [CNT_W-1:0] cnt
);

  logic [WIDTH-1:0] lo, hi, m;
  logic             is_div;
  logic [WIDTH:0]   sum, shifted;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // lo starts as the multiplier / dividend and ends as product-low / quotient.
  always_comb begin
    sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    shifted = {hi, lo[WIDTH-1]};
    ge      = shifted >= {1'b0, m};
    // When ge holds the difference is below m, so the low WIDTH bits are exact.
    diff    = shifted[WIDTH-1:0] - m;
    if (is_div) begin
      lo_next = {lo[WIDTH-2:0], ge};
      hi_next = ge ? diff : shifted[WIDTH-1:0];
    end else begin
      lo_next = {sum[0], lo[WIDTH-1:1]};
      hi_next = sum[WIDTH:1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lo     <= '0;
      hi     <= '0;
      m      <= '0;
      is_div <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      lo     <= a;
      hi     <= '0;
      m      <= b;
      is_div <= load_div;
      cnt    <= '0;
    end else if (step) begin
      lo  <= lo_next;
      hi  <= hi_next;
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ula_seq.sv
// rtl/ula_seq.sv - registered ULA with start/done handshake, flag bank and iterative MUL/DIV
module ula_seq
  import ula_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       cod,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] C_hi,
  output logic             zero,
  output logic             negativo,
  output logic             Carry,
  output logic             overflow,
  output logic             maior,
  output logic             menor,
  output logic             igual,
  output logic             div_zero
);

  state_t               state;
  logic [NUM_FLAGS-1:0] flags;
  logic [2:0]           cmp, cmp_q;
  logic                 is_mul, is_div, div_by0, load, step, last;
  logic [WIDTH-1:0]     lo_next, hi_next;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH:0]       add, sub;
  logic [WIDTH-1:0]     s_c, s_chi;
  logic                 s_carry, s_ovf, s_neg, s_dz;
  logic [NUM_FLAGS-1:0] s_flags;

  assign is_mul  = (cod == ULA_MUL);
  assign is_div  = (cod == ULA_DIV);
  assign div_by0 = is_div && (B == '0);
  assign load    = (state == IDLE || state == DONE) && start && (is_mul || (is_div && !div_by0));
  assign step    = (state == MUL_ITER) || (state == DIV_ITER);
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  ula_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_div (is_div),
    .step     (step),
    .a        (A),
    .b        (B),
    .lo_next  (lo_next),
    .hi_next  (hi_next),
    .cnt      (cnt)
  );

  always_comb begin
    add     = {1'b0, A} + {1'b0, B};
    sub     = {1'b0, A} - {1'b0, B};
    cmp     = {A > B, A < B, A == B};
    s_c     = A;
    s_chi   = '0;
    s_carry = 1'b0;
    s_ovf   = 1'b0;
    s_neg   = 1'b0;
    s_dz    = 1'b0;
    case (cod)
      ULA_ADD: begin
        s_c     = add[WIDTH-1:0];
        s_carry = add[WIDTH];
        s_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (add[WIDTH-1] != A[WIDTH-1]);
      end
      ULA_SUB: begin
        s_c     = sub[WIDTH-1:0];
        s_carry = sub[WIDTH];
        s_neg   = sub[WIDTH];
        s_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (sub[WIDTH-1] != A[WIDTH-1]);
      end
      ULA_AND:   s_c = A & B;
      ULA_OR:    s_c = A | B;
      ULA_NOT:   s_c = ~A;
      ULA_SHL: begin
        s_c     = {A[WIDTH-2:0], 1'b0};
        s_carry = A[WIDTH-1];
      end
      ULA_PASSB: s_c = B;
      // Only the B=0 divide takes the single-cycle path.
      ULA_DIV: begin
        s_c   = '1;
        s_chi = A;
        s_dz  = 1'b1;
      end
      default:   s_c = A;
    endcase
    s_flags = pack_flags((s_c == '0) && (s_chi == '0), s_neg, s_carry, s_ovf, cmp, s_dz);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      C     <= '0;
      C_hi  <= '0;
      flags <= '0;
      cmp_q <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cmp_q <= cmp;
            if (is_mul) begin
              state <= MUL_ITER;
              busy  <= 1'b1;
            end else if (is_div && !div_by0) begin
              state <= DIV_ITER;
              busy  <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
              C     <= s_c;
              C_hi  <= s_chi;
              flags <= s_flags;
            end
          end else begin
            state <= IDLE;
          end
        end
        MUL_ITER, DIV_ITER: begin
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            C     <= lo_next;
            C_hi  <= hi_next;
            flags <= pack_flags((lo_next == '0) && (hi_next == '0), 1'b0, 1'b0, 1'b0, cmp_q, 1'b0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero     = flags[FLAG_ZERO];
  assign negativo = flags[FLAG_NEG];
  assign Carry    = flags[FLAG_CARRY];
  assign overflow = flags[FLAG_OVF];
  assign maior    = flags[FLAG_MAIOR];
  assign menor    = flags[FLAG_MENOR];
  assign igual    = flags[FLAG_IGUAL];
  assign div_zero = flags[FLAG_DIVZ];

endmodule

// File: tb/tb_ula_seq.sv
// tb/tb_ula_seq.sv - directed scoreboard bench for ula_seq at WIDTH=8 and WIDTH=16
module tb_ula_seq;
  import ula_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, sel;
  logic [3:0]  cod;
  logic [15:0] a, b;
  logic        start8, start16;

  logic        busy8, done8, z8, n8, cy8, ov8, ma8, me8, ig8, dz8;
  logic [7:0]  c8, chi8;
  logic        busy16, done16, z16, n16, cy16, ov16, ma16, me16, ig16, dz16;
  logic [15:0] c16, chi16;

  logic        obs_busy, obs_done;
  logic [15:0] obs_c, obs_chi;
  logic [7:0]  obs_f;

  typedef struct {
    logic [15:0] c;
    logic [15:0] chi;
    logic [7:0]  f;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  assign start8  = start & ~sel;
  assign start16 = start & sel;

  ula_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .cod(cod), .A(a[7:0]), .B(b[7:0]),
    .busy(busy8), .done(done8), .C(c8), .C_hi(chi8),
    .zero(z8), .negativo(n8), .Carry(cy8), .overflow(ov8),
    .maior(ma8), .menor(me8), .igual(ig8), .div_zero(dz8)
  );

  ula_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .cod(cod), .A(a), .B(b),
    .busy(busy16), .done(done16), .C(c16), .C_hi(chi16),
    .zero(z16), .negativo(n16), .Carry(cy16), .overflow(ov16),
    .maior(ma16), .menor(me16), .igual(ig16), .div_zero(dz16)
  );

  // flags packed as {zero, negativo, Carry, overflow, maior, menor, igual, div_zero}
  always_comb begin
    if (sel) begin
      obs_busy = busy16;
      obs_done = done16;
      obs_c    = c16;
      obs_chi  = chi16;
      obs_f    = {z16, n16, cy16, ov16, ma16, me16, ig16, dz16};
    end else begin
      obs_busy = busy8;
      obs_done = done8;
      obs_c    = {8'h00, c8};
      obs_chi  = {8'h00, chi8};
      obs_f    = {z8, n8, cy8, ov8, ma8, me8, ig8, dz8};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [3:0] op,
                                 input longint unsigned x, input longint unsigned y);
    exp_t e;
    longint unsigned mask, r, hi, p;
    bit cy, ov, ng, dz, sx, sy, sr;
    mask = (64'd1 << w) - 64'd1;
    r = x; hi = 0; cy = 0; ov = 0; ng = 0; dz = 0;
    e.lat = 1;
    sx = x[w-1];
    sy = y[w-1];
    case (op)
      4'd0: begin r = (x + y) & mask; cy = ((x + y) >> w) != 0; sr = r[w-1]; ov = (sx == sy) && (sr != sx); end
      4'd1: begin r = (x - y) & mask; cy = x < y; ng = x < y; sr = r[w-1]; ov = (sx != sy) && (sr != sx); end
      4'd2: r = x & y;
      4'd3: r = x | y;
      4'd4: r = ~x & mask;
      4'd5: begin r = (x << 1) & mask; cy = sx; end
      4'd7: r = y;
      4'd8: begin p = x * y; r = p & mask; hi = p >> w; e.lat = w + 1; end
      4'd9: begin
        if (y == 0) begin r = mask; hi = x; dz = 1; end
        else begin r = x / y; hi = x % y; e.lat = w + 1; end
      end
      default: r = x;
    endcase
    e.c   = r[15:0];
    e.chi = hi[15:0];
    e.f   = {(r == 0) && (hi == 0), ng, cy, ov, x > y, x < y, x == y, dz};
    return e;
  endfunction

  // poke raises an ignored start (ADD with different A) while a multi-cycle op is busy
  task automatic issue(input logic s, input logic [3:0] op, input logic [15:0] av,
                       input logic [15:0] bv, input bit poke);
    exp_t e;
    int   edges, bcnt;
    sb.push_back(model(s ? 16 : 8, op, {48'd0, av}, {48'd0, bv}));
    @(negedge clk);
    sel = s; cod = op; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    bcnt  = 0;
    while (!obs_done && edges < 200) begin
      if (obs_busy) bcnt++;
      start = poke && (edges == 3);
      if (start) begin cod = ULA_ADD; a = 16'h0011; end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done", 64'(obs_done), 64'(1));
    check("latency", 64'(edges), 64'(e.lat));
    check("busy_cycles", 64'(bcnt), 64'(e.lat - 1));
    check("C", 64'(obs_c), 64'(e.c));
    check("C_hi", 64'(obs_chi), 64'(e.chi));
    check("flags", 64'(obs_f), 64'(e.f));
    @(posedge clk); #1;
    check("done_pulse", 64'(obs_done), 64'(0));
  endtask

  initial begin
    exp_t e;
    int   nd;
    reset = 1'b1; start = 1'b0; sel = 1'b0; cod = 4'd0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    check("reset8", 64'({busy8, done8, c8, chi8, z8, n8, cy8, ov8, ma8, me8, ig8, dz8}), 64'(0));
    check("reset16", 64'({busy16, done16, c16, chi16, z16, n16, cy16, ov16, ma16, me16, ig16, dz16}), 64'(0));

    issue(1'b0, ULA_ADD,   16'd200, 16'd100, 1'b0);
    issue(1'b0, ULA_SUB,   16'd5,   16'd9,   1'b0);
    issue(1'b0, ULA_SUB,   16'd7,   16'd7,   1'b0);
    issue(1'b0, ULA_ADD,   16'h7F,  16'h01,  1'b0);
    issue(1'b0, ULA_SUB,   16'h80,  16'h01,  1'b0);
    issue(1'b0, ULA_AND,   16'hC3,  16'h5A,  1'b0);
    issue(1'b0, ULA_OR,    16'hC3,  16'h5A,  1'b0);
    issue(1'b0, ULA_NOT,   16'h0F,  16'h00,  1'b0);
    issue(1'b0, ULA_SHL,   16'h81,  16'h02,  1'b0);
    issue(1'b0, ULA_PASSA, 16'h80,  16'h10,  1'b0);
    issue(1'b0, ULA_PASSB, 16'h00,  16'h00,  1'b0);
    issue(1'b0, 4'd12,     16'd33,  16'd44,  1'b0);
    issue(1'b0, ULA_MUL,   16'd255, 16'd255, 1'b1);
    issue(1'b0, ULA_DIV,   16'd200, 16'd7,   1'b1);
    issue(1'b0, ULA_DIV,   16'd13,  16'd0,   1'b0);
    issue(1'b0, ULA_MUL,   16'd0,   16'd77,  1'b0);
    issue(1'b0, ULA_DIV,   16'd5,   16'd9,   1'b0);
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, ULA_MUL, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0);
      issue(1'b0, ULA_DIV, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 1'b0);
    end

    // back-to-back single-cycle ops: done on consecutive cycles
    sb.push_back(model(8, ULA_ADD, 64'd10, 64'd20));
    sb.push_back(model(8, ULA_SUB, 64'd3, 64'd1));
    @(negedge clk);
    sel = 1'b0; cod = ULA_ADD; a = 16'd10; b = 16'd20; start = 1'b1;
    @(posedge clk); #1;
    e = sb.pop_front();
    check("b2b_done1", 64'(obs_done), 64'(1));
    check("b2b_C1", 64'(obs_c), 64'(e.c));
    check("b2b_flags1", 64'(obs_f), 64'(e.f));
    cod = ULA_SUB; a = 16'd3; b = 16'd1;
    @(posedge clk); #1;
    start = 1'b0;
    e = sb.pop_front();
    check("b2b_done2", 64'(obs_done), 64'(1));
    check("b2b_C2", 64'(obs_c), 64'(e.c));
    check("b2b_flags2", 64'(obs_f), 64'(e.f));
    @(posedge clk); #1;
    check("b2b_done_drop", 64'(obs_done), 64'(0));

    // reset in the middle of a MUL
    @(negedge clk);
    sel = 1'b0; cod = ULA_MUL; a = 16'd255; b = 16'd255; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy", 64'(obs_busy), 64'(1));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", 64'(obs_busy), 64'(0));
    check("rst_outs", 64'({obs_done, obs_c, obs_chi, obs_f}), 64'(0));
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (obs_done) nd++;
    end
    check("rst_no_done", 64'(nd), 64'(0));
    issue(1'b0, ULA_ADD, 16'd200, 16'd100, 1'b0);

    // WIDTH=16 instance
    issue(1'b1, ULA_MUL, 16'hFFFF, 16'h0002, 1'b0);
    issue(1'b1, ULA_SHL, 16'h8001, 16'h0000, 1'b0);
    issue(1'b1, ULA_DIV, 16'hFFFF, 16'h0100, 1'b1);
    issue(1'b1, ULA_ADD, 16'hFFFF, 16'h0001, 1'b0);
    issue(1'b1, ULA_DIV, 16'h1234, 16'h0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, registered successor to the 8-bit combinational ULA used by the CPU datapath. It adds a start/done handshake, a registered flag bank and two multi-cycle operations: unsigned shift-add multiply and restoring divide. The control unit issues one operation at a time and waits on done before reading C, C_hi and the flags.

Parameters:
WIDTH, 8, operand and result width in bits (>= 2).
CNT_W, $clog2(WIDTH+1), width of the iteration counter (derived, not overridden).

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high; clears all state on the next rising edge
start  in  1  request; sampled only while busy=0
cod  in  4  operation code, latched with start
A  in  WIDTH  operand A, latched with start
B  in  WIDTH  operand B, latched with start
busy  out  1  high while a multi-cycle operation is iterating
done  out  1  one-cycle pulse: C, C_hi and flags valid from this cycle on
C  out  WIDTH  result, or low half of the product, or quotient
C_hi  out  WIDTH  high half of the product, or remainder; 0 for other ops
zero, negativo, Carry, overflow  out  1 each  arithmetic flags
maior, menor, igual  out  1 each  unsigned compare of the latched A and B
div_zero  out  1  DIV attempted with B=0

Behaviour:
- Reset: state IDLE; busy=0, done=0, C=0, C_hi=0, every flag 0. This takes priority over everything else, including a reset during an iteration. A partial result is never exposed.
- Opcodes:
  - 0 ADD: A+B
  - 1 SUB: A-B
  - 2 AND
  - 3 OR
  - 4 NOT A
  - 5 SHL: A<<1
  - 6 PASSA
  - 7 PASSB
  - 8 MUL
  - 9 DIV
  - 10-15: treated as PASSA.
- Outputs C, C_hi and the flags hold their value until the next done.
- Single-cycle ops (0-7, 10-15):
  - On the edge where start=1 and busy=0, the result and flags are registered and done=1 for the following cycle. Latency is 1.
  - busy never rises.
- MUL:
  - On the start edge, go to MUL_ITER with busy=1. Run WIDTH shift-add iterations.
  - On the final iteration edge, register the 2*WIDTH product as {C_hi,C}, go to DONE, drop busy and pulse done.
  - Latency is WIDTH+1 edges from the start edge (9 for WIDTH=8).
- DIV: restoring, WIDTH iterations in DIV_ITER. Quotient goes to C, remainder to C_hi, with the same latency as MUL.
- DIV with B=0: no iteration. Latency is 1. C = all ones, C_hi = A, div_zero=1.
- FSM states: IDLE -> (start & MUL) MUL_ITER, (start & DIV & B!=0) DIV_ITER, other start -> DONE. From MUL_ITER or DIV_ITER, go to DONE when the counter reaches WIDTH-1. DONE -> IDLE after one cycle.
- Back-to-back issue: start is accepted in DONE, so a new single-cycle op can produce done on consecutive cycles.
- start while busy=1 is ignored. No queueing.
- Flags are updated only together with done:
  - zero=1 if C==0 and C_hi==0.
  - Carry = carry out of ADD; borrow (A<B) for SUB; the bit shifted out (A[WIDTH-1]) for SHL; 0 otherwise.
  - negativo=1 only for SUB with A<B.
  - overflow = two's-complement overflow for ADD and SUB; 0 otherwise.
  - maior/menor/igual: exactly one is set, from an unsigned compare of the latched A and B, for every op.
  - div_zero: 0 except in the B=0 DIV case.
- Arithmetic: all unsigned, modulo 2^WIDTH. No sign extension anywhere.

Decomposition:
- Shared package ula_pkg holds:
  - opcode localparams (ULA_ADD .. ULA_DIV);
  - the FSM state encoding (IDLE, MUL_ITER, DIV_ITER, DONE);
  - a flag-bundle ordering constant, so the control unit indexes flags consistently.
- One natural sub-module: ula_muldiv_iter. It holds the shared accumulator, shift register and counter datapath for MUL and DIV. The parent owns the FSM, the single-cycle ops and the flag logic.

Test Plan:
- WIDTH=8, ADD A=200 B=100 -> next cycle done=1, C=44, Carry=1, overflow=0, maior=1, busy never high.
- SUB A=5 B=9 -> C=252, negativo=1, Carry=1, menor=1, zero=0. SUB A=7 B=7 -> C=0, zero=1, igual=1.
- MUL A=255 B=255 -> busy high for 8 cycles, done exactly 9 edges after start, C_hi=254, C=1. A second start issued while busy is ignored.
- DIV A=200 B=7 -> C=28, C_hi=4, done at edge 9. DIV A=13 B=0 -> done after 1 edge, C=255, C_hi=13, div_zero=1.
- reset asserted at iteration 4 of a MUL -> next edge busy=0, C=0, all flags 0, no done. A new ADD issued afterwards completes normally.
- WIDTH=16 parameter sweep: MUL 0xFFFF*2 -> C_hi=0x0001, C=0xFFFE, latency 17. SHL 0x8001 -> C=0x0002, Carry=1.
